// File: rtl/scariv_credit_return_sched.sv
// Credit return scheduler for one backend resource.
// Batches per-cycle entry releases into bounded credit returns toward the
// allocator's credit master. Returns freeze during a flush, and all withheld
// credits are drained once the backend reports that the kill is complete.
module scariv_credit_return_sched #(
  parameter int MAX_CREDITS   = 16,
  parameter int REL_PORTS     = 2,
  parameter int MAX_RET       = 2,
  parameter int RET_THRESHOLD = 2,
  parameter int TIMEOUT       = 4,
  parameter int CNT_W         = $clog2(MAX_CREDITS) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [REL_PORTS-1:0] i_release_valid,
  input  logic                 i_flush,
  input  logic                 i_flush_done,
  output logic                 o_return_valid,
  output logic [CNT_W-1:0]     o_return_val,
  input  logic                 i_return_ready,
  output logic [CNT_W-1:0]     o_pending,
  output logic [1:0]           o_state,
  output logic                 o_overflow_err
);

  localparam logic [1:0] ST_NORMAL = 2'd0;
  localparam logic [1:0] ST_FLUSH  = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;

  // Two extra bits so the pending sum can exceed MAX_CREDITS without wrapping.
  localparam int SUM_W = CNT_W + 2;
  localparam int TMR_W = $clog2(TIMEOUT + 2);

  localparam logic [CNT_W-1:0] MAX_RET_C   = CNT_W'(MAX_RET);
  localparam logic [CNT_W-1:0] THRESHOLD_C = CNT_W'(RET_THRESHOLD);
  localparam logic [CNT_W-1:0] MAX_CRED_C  = CNT_W'(MAX_CREDITS);
  localparam logic [TMR_W-1:0] TIMEOUT_C   = TMR_W'(TIMEOUT);

  logic [CNT_W-1:0] pend_reg, pend_next;
  logic [TMR_W-1:0] timer_reg, timer_next;
  logic [1:0]       state_reg, state_next;
  logic             ret_valid_reg, ret_valid_next;
  logic [CNT_W-1:0] ret_val_reg, ret_val_next;
  logic             overflow_reg, overflow_next;

  logic [SUM_W-1:0] rel_cnt;
  logic [SUM_W-1:0] pend_sum;
  logic             slot_avail;
  logic             xfer;
  logic             pend_nz;
  logic             timed_out;
  logic             load;
  logic [CNT_W-1:0] load_val;

  // Number of entries released this cycle.
  always_comb begin
    rel_cnt = '0;
    for (int i = 0; i < REL_PORTS; i++) begin
      rel_cnt = rel_cnt + SUM_W'(i_release_valid[i]);
    end
  end

  // Load decision: the output slot is free (or emptying now) and the state allows a return.
  always_comb begin
    slot_avail = !ret_valid_reg || i_return_ready;
    xfer       = ret_valid_reg && i_return_ready;
    pend_nz    = (pend_reg != '0);
    timed_out  = (timer_reg == TIMEOUT_C);
    load       = 1'b0;
    case (state_reg)
      ST_NORMAL: load = slot_avail && ((pend_reg >= THRESHOLD_C) || (pend_nz && timed_out));
      ST_DRAIN:  load = slot_avail && pend_nz;
      default:   load = 1'b0;
    endcase
    // Load amount comes from the registered count; this cycle's releases wait.
    load_val = '0;
    if (load) begin
      load_val = (pend_reg > MAX_RET_C) ? MAX_RET_C : pend_reg;
    end
  end

  // Pending count update with saturation and sticky overflow flag.
  always_comb begin
    pend_sum      = SUM_W'(pend_reg) - SUM_W'(load_val) + rel_cnt;
    pend_next     = pend_sum[CNT_W-1:0];
    overflow_next = overflow_reg;
    if (pend_sum > SUM_W'(MAX_CREDITS)) begin
      pend_next     = MAX_CRED_C;
      overflow_next = 1'b1;
    end
  end

  // Idle timer: counts cycles with credits held but nothing loaded; frozen at 0 in FLUSH.
  always_comb begin
    timer_next = timer_reg;
    if ((state_reg == ST_FLUSH) || load || !pend_nz) begin
      timer_next = '0;
    end else if (!timed_out) begin
      timer_next = timer_reg + 1'b1;
    end
  end

  // Offered return: held stable until a transfer; refilled in the same cycle a transfer fires.
  always_comb begin
    ret_valid_next = ret_valid_reg;
    ret_val_next   = ret_val_reg;
    if (load) begin
      ret_valid_next = 1'b1;
      ret_val_next   = load_val;
    end else if (xfer) begin
      ret_valid_next = 1'b0;
    end
  end

  // Flush state machine: flush wins over drain completion; flush_done only matters in FLUSH.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_NORMAL: if (i_flush) state_next = ST_FLUSH;
      ST_FLUSH:  if (i_flush_done) state_next = ST_DRAIN;
      ST_DRAIN: begin
        if (i_flush) begin
          state_next = ST_FLUSH;
        end else if (!pend_nz && !load) begin
          state_next = ST_NORMAL;
        end
      end
      default:   state_next = ST_NORMAL;
    endcase
  end

  // State registers; reset discards any offered return and all pending credits.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      pend_reg      <= '0;
      timer_reg     <= '0;
      state_reg     <= ST_NORMAL;
      ret_valid_reg <= 1'b0;
      ret_val_reg   <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      pend_reg      <= pend_next;
      timer_reg     <= timer_next;
      state_reg     <= state_next;
      ret_valid_reg <= ret_valid_next;
      ret_val_reg   <= ret_val_next;
      overflow_reg  <= overflow_next;
    end
  end

  assign o_return_valid = ret_valid_reg;
  assign o_return_val   = ret_val_reg;
  assign o_pending      = pend_reg;
  assign o_state        = state_reg;
  assign o_overflow_err = overflow_reg;

endmodule

// File: tb/tb_scariv_credit_return_sched.sv
// Bench for the credit return scheduler: directed scenarios followed by
// random traffic, checked against a cycle-level reference model and a
// scoreboard of expected return values.
module tb_scariv_credit_return_sched;

  localparam int MAX_CREDITS   = 16;
  localparam int REL_PORTS     = 2;
  localparam int MAX_RET       = 2;
  localparam int RET_THRESHOLD = 2;
  localparam int TIMEOUT       = 4;
  localparam int CNT_W         = $clog2(MAX_CREDITS) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [REL_PORTS-1:0] rel;
  logic                 flush;
  logic                 flush_done;
  logic                 ret_valid;
  logic [CNT_W-1:0]     ret_val;
  logic                 ret_ready;
  logic [CNT_W-1:0]     pending;
  logic [1:0]           state;
  logic                 ovf;

  always #5 clk = ~clk;

  scariv_credit_return_sched #(
    .MAX_CREDITS(MAX_CREDITS), .REL_PORTS(REL_PORTS), .MAX_RET(MAX_RET),
    .RET_THRESHOLD(RET_THRESHOLD), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_release_valid(rel), .i_flush(flush),
    .i_flush_done(flush_done), .o_return_valid(ret_valid), .o_return_val(ret_val),
    .i_return_ready(ret_ready), .o_pending(pending), .o_state(state),
    .o_overflow_err(ovf)
  );

  int errors = 0;
  int checks = 0;
  int exp_q[$];

  // Reference model state (value expected after the next clock edge).
  int m_pend, m_timer, m_state, m_rv, m_rval, m_ovf;
  int tot_rel, tot_xfer;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_timer = 0; m_state = 0; m_rv = 0; m_rval = 0; m_ovf = 0;
    tot_rel = 0; tot_xfer = 0;
    exp_q.delete();
  endtask

  // One cycle of the rules: load from the held count, then add releases.
  task automatic model_step(input int r, input bit fl, input bit fd, input bit rdy);
    bit slot, fire, ld;
    int lv, np, nstate, ntimer;
    slot = (m_rv == 0) || rdy;
    fire = (m_rv != 0) && rdy;
    if (m_state == 0)      ld = slot && (m_pend >= RET_THRESHOLD || (m_pend > 0 && m_timer == TIMEOUT));
    else if (m_state == 2) ld = slot && (m_pend > 0);
    else                   ld = 0;
    lv = ld ? ((m_pend < MAX_RET) ? m_pend : MAX_RET) : 0;
    np = m_pend - lv + r;
    if (np > MAX_CREDITS) begin np = MAX_CREDITS; m_ovf = 1; end
    if (m_state == 1 || ld || m_pend == 0) ntimer = 0;
    else ntimer = (m_timer + 1 > TIMEOUT) ? TIMEOUT : m_timer + 1;
    nstate = m_state;
    if (m_state == 0 && fl) nstate = 1;
    else if (m_state == 1 && fd) nstate = 2;
    else if (m_state == 2) nstate = fl ? 1 : ((m_pend == 0 && !ld) ? 0 : 2);
    tot_rel += r;
    if (fire) tot_xfer += m_rval;
    if (ld) begin
      m_rv = 1; m_rval = lv; exp_q.push_back(lv);
    end else if (fire) begin
      m_rv = 0;
    end
    m_pend = np; m_timer = ntimer; m_state = nstate;
  endtask

  // Check current outputs against the model, then drive one cycle of inputs.
  task automatic step(input logic [1:0] r, input bit fl, input bit fd, input bit rdy, input bit rs);
    @(negedge clk);
    chk("pending", int'(pending), m_pend);
    chk("state", int'(state), m_state);
    chk("overflow", int'(ovf), m_ovf);
    chk("ret_valid", int'(ret_valid), m_rv);
    if (m_ovf == 0)
      chk("conservation", tot_rel, tot_xfer + int'(pending) + (ret_valid ? int'(ret_val) : 0));
    rel = r; flush = fl; flush_done = fd; ret_ready = rdy; rst = rs;
    if (rs) model_reset();
    else model_step($countones(r), fl, fd, rdy);
  endtask

  task automatic rst_seq();
    step(2'b00, 0, 0, 0, 1);
  endtask

  // Monitor: every offered return must match the scoreboard head; pop on transfer.
  always @(negedge clk) begin
    #1;
    if (!rst && ret_valid) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_return: got val %0d expected no return (t=%0t)", ret_val, $time);
      end else begin
        chk("return_val", int'(ret_val), exp_q[0]);
        if (ret_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; rel = '0; flush = 0; flush_done = 0; ret_ready = 0;
    model_reset();

    // Reset with a return offered and releases in flight.
    rst_seq();
    step(2'b11, 0, 0, 0, 0);
    step(2'b01, 0, 0, 0, 0);
    step(2'b11, 0, 0, 1, 1);
    step(2'b00, 0, 0, 1, 0);
    chk("reset_valid", int'(ret_valid), 0);
    chk("reset_pending", int'(pending), 0);
    chk("reset_state", int'(state), 0);
    chk("reset_ovf", int'(ovf), 0);

    // Threshold return.
    rst_seq();
    step(2'b11, 0, 0, 1, 0);
    step(2'b00, 0, 0, 1, 0);
    chk("thr_pend_c1", int'(pending), 2);
    step(2'b00, 0, 0, 1, 0);
    chk("thr_valid_c2", int'(ret_valid), 1);
    chk("thr_val_c2", int'(ret_val), 2);
    chk("thr_pend_c2", int'(pending), 0);

    // Timeout return.
    rst_seq();
    step(2'b01, 0, 0, 1, 0);
    for (int c = 1; c <= 5; c++) begin
      step(2'b00, 0, 0, 1, 0);
      chk("to_pend", int'(pending), 1);
      chk("to_no_valid", int'(ret_valid), 0);
    end
    step(2'b00, 0, 0, 1, 0);
    chk("to_valid_c6", int'(ret_valid), 1);
    chk("to_val_c6", int'(ret_val), 1);

    // Backpressure.
    rst_seq();
    step(2'b11, 0, 0, 1, 0);
    step(2'b11, 0, 0, 1, 0);
    step(2'b11, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 0);
    step(2'b00, 0, 0, 0, 0);
    chk("bp_pend_c4", int'(pending), 6);
    chk("bp_val_c4", int'(ret_val), 2);
    for (int c = 5; c <= 8; c++) begin
      step(2'b00, 0, 0, 1, 0);
      chk("bp_drain_valid", int'(ret_valid), 1);
      chk("bp_drain_val", int'(ret_val), 2);
    end
    step(2'b00, 0, 0, 1, 0);
    chk("bp_done_valid", int'(ret_valid), 0);
    chk("bp_done_pend", int'(pending), 0);

    // Flush then drain.
    rst_seq();
    step(2'b11, 0, 0, 0, 0);
    step(2'b01, 0, 0, 0, 0);
    step(2'b11, 0, 0, 0, 0);
    step(2'b00, 1, 0, 0, 0);
    chk("fl_pend_c3", int'(pending), 3);
    step(2'b11, 0, 0, 1, 0);
    step(2'b11, 0, 0, 1, 0);
    chk("fl_no_valid_c5", int'(ret_valid), 0);
    step(2'b00, 0, 1, 1, 0);
    chk("fl_no_valid_c6", int'(ret_valid), 0);
    step(2'b00, 0, 0, 1, 0);
    chk("fl_state_drain", int'(state), 2);
    chk("fl_pend_c7", int'(pending), 7);
    for (int c = 8; c <= 11; c++) begin
      step(2'b00, 0, 0, 1, 0);
      chk("fl_drain_val", int'(ret_val), (c == 11) ? 1 : 2);
    end
    step(2'b00, 0, 0, 1, 0);
    chk("fl_state_normal", int'(state), 0);

    // Overflow during FLUSH stays sticky until reset.
    rst_seq();
    step(2'b00, 1, 0, 1, 0);
    for (int c = 1; c <= 17; c++) step(2'b01, 0, 0, 1, 0);
    step(2'b00, 0, 1, 1, 0);
    chk("ovf_pend_sat", int'(pending), 16);
    chk("ovf_flag", int'(ovf), 1);
    for (int c = 0; c < 12; c++) step(2'b00, 0, 0, 1, 0);
    chk("ovf_back_normal", int'(state), 0);
    chk("ovf_sticky", int'(ovf), 1);
    rst_seq();
    step(2'b00, 0, 0, 1, 0);
    chk("ovf_cleared", int'(ovf), 0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      step(2'($urandom), $urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 499) == 0);
    end

    // Drain everything and confirm the scoreboard emptied.
    for (int n = 0; n < 40; n++) step(2'b00, 0, 1, 1, 0);
    step(2'b00, 0, 0, 1, 0);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_valid", int'(ret_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/scariv_credit_return_sched.md
Name: scariv_credit_return_sched

Overview:
- Slave-side credit return scheduler for one backend resource (issue queue, LDQ, STQ, ROB) whose credits are consumed by the dispatch-stage resource allocator.
- Collects per-cycle entry releases from the backend and batches them into bounded credit returns toward the allocator's credit master over a valid/ready channel.
- Freezes returns during a pipeline flush, then drains all withheld credits once the flush completes.

Parameters:
- MAX_CREDITS, 16, total entries of the resource; pending count never legally exceeds this.
- REL_PORTS, 2, number of single-entry release ports per cycle.
- MAX_RET, 2, maximum credits carried by one return transfer (1..MAX_CREDITS).
- RET_THRESHOLD, 2, pending count at which a return is issued in NORMAL state.
- TIMEOUT, 4, idle cycles after which a sub-threshold nonzero pending count is returned anyway.
- CNT_W, $clog2(MAX_CREDITS)+1, width of count fields.

Ports:
- i_clk  input  1  clock.
- i_reset  input  1  synchronous reset, active-high.
- i_release_valid  input  REL_PORTS  each set bit frees one entry this cycle.
- i_flush  input  1  pipeline flush start.
- i_flush_done  input  1  backend kill complete; releases for killed entries have all been presented.
- o_return_valid  output  1  credit return offered.
- o_return_val  output  CNT_W  credits in the offered return (1..MAX_RET).
- i_return_ready  input  1  master accepts the return; transfer = valid & ready.
- o_pending  output  CNT_W  credits held, not yet offered.
- o_state  output  2  0=NORMAL, 1=FLUSH, 2=DRAIN.
- o_overflow_err  output  1  sticky: pending would exceed MAX_CREDITS.

Behaviour:
- Reset: all outputs 0, state NORMAL, idle timer 0. Reset mid-transfer discards the offered return and all pending credits.
- Pending update each cycle: pend_next = pend - load_val + popcount(i_release_valid).
  - If the result exceeds MAX_CREDITS: saturate at MAX_CREDITS and set o_overflow_err. It clears only on reset.
- Load slot: available when !o_return_valid, or when a transfer fires this cycle.
  - On load: o_return_valid=1 next cycle, o_return_val=min(pend, MAX_RET), computed from the registered pend (this cycle's releases excluded). pend is reduced in the same cycle.
- Offered return holds: o_return_valid and o_return_val stay stable until a transfer. Valid never drops without a transfer, in any state.
- Latency: release in cycle t -> pend visible t+1 -> earliest o_return_valid t+2.
- Idle timer:
  - Increments each cycle pend>0 and no load occurs; saturates at TIMEOUT.
  - Clears on load or when pend==0.
- NORMAL: load when slot available and (pend >= RET_THRESHOLD, or pend>0 and timer==TIMEOUT).
- FLUSH: entered when i_flush=1 in NORMAL or DRAIN.
  - No new loads; an already-offered return completes normally.
  - Releases keep accumulating; the timer is held at 0.
  - i_flush_done=1 -> DRAIN. If i_flush and i_flush_done are both set in FLUSH, go to DRAIN.
- DRAIN: load whenever the slot is available and pend>0, ignoring threshold and timer.
  - Go to NORMAL when pend==0 and no load occurs that cycle.
  - i_flush=1 in DRAIN -> FLUSH, and i_flush has priority.
- i_flush_done is ignored outside FLUSH; i_flush is ignored inside FLUSH.
- Conservation invariant, absent overflow: total releases = total transferred credits + pend + (o_return_valid ? o_return_val : 0).

Test Plan:
Defaults throughout: MAX_CREDITS=16, REL_PORTS=2, MAX_RET=2, RET_THRESHOLD=2, TIMEOUT=4.
- Reset: assert i_reset with 3 releases in flight -> next cycle o_return_valid=0, o_pending=0, o_state=0, o_overflow_err=0.
- Threshold return: release 2'b11 in cycle 0, ready=1 -> o_pending=2 at c1, o_return_valid=1 with val=2 at c2, o_pending=0 at c2.
- Timeout return: release 1 entry at c0, then idle -> pend=1 from c1, timer reaches 4 at c5, o_return_valid=1 with val=1 at c6.
- Backpressure: ready=0 for cycles 2-4 while releasing 2/cycle -> val stays 2 and stable, pend grows to 6. Ready=1 from c5 -> returns of 2 on consecutive cycles until drained; conservation holds.
- Flush: pend=3, i_flush, then 4 releases during FLUSH -> no new o_return_valid. i_flush_done -> DRAIN returns 2,2,2,1 back-to-back with ready=1, then o_state=0.
- Overflow: in FLUSH, 17 single releases -> o_pending saturates at 16, o_overflow_err=1, and it stays 1 through DRAIN and back to NORMAL until reset.
